// File: rtl/diff_order_calc_mc.sv
// diff_order_calc_mc: multi-channel integer difference-order calculator.
// For each channel c it finds the smallest n >= 0 such that BG * TOE^n <= L[c].
// L[c] is a level in mV. The search scales a fixed-point accumulator by TOE
// once per cycle. Channels are processed one after another under a
// start/done handshake.
// Optional build macro DIFF_ORDER_CACHE_EN adds a per-channel result cache.
// With the cache, a channel whose level is unchanged since its last stored
// result is skipped in a single cycle.
module diff_order_calc_mc #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 12,
    parameter int FRAC_W   = 16,
    parameter int N_W      = 16,
    parameter int N_MAX    = 40,
    parameter int BG_Q     = 63163597,
    parameter int TOE_Q    = 30782
) (
    input  logic                       clk_50,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       start,
    input  logic [CHANNELS*DATA_W-1:0] l_mv,
    output logic                       busy,
    output logic                       done,
    output logic [CHANNELS*N_W-1:0]    n_out,
    output logic [CHANNELS-1:0]        sat
);

    localparam int ACC_W  = DATA_W + FRAC_W;
    localparam int PROD_W = DATA_W + 2 * FRAC_W;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [ACC_W-1:0]  BG_V    = ACC_W'(BG_Q);
    localparam logic [FRAC_W-1:0] TOE_V   = FRAC_W'(TOE_Q);
    localparam logic [N_W-1:0]    N_MAX_V = N_W'(N_MAX);
    localparam logic [CH_W-1:0]   CH_LAST = CH_W'(CHANNELS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ITER  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                         state;
    logic [CHANNELS-1:0][DATA_W-1:0]    l_reg;
    logic [CH_W-1:0]                    ch;
    logic [ACC_W-1:0]                   x;
    logic [N_W-1:0]                     n;
    logic                               sat_i;
    logic [CHANNELS-1:0][N_W-1:0]       n_reg;
    logic [CHANNELS-1:0]                sat_reg;

    logic [DATA_W-1:0]                  l_cur;
    logic [ACC_W-1:0]                   l_thr;
    logic [PROD_W-1:0]                  prod;
    logic [ACC_W-1:0]                   x_next;
    logic                               last_ch;
    logic                               cache_hit;

    assign n_out = n_reg;
    assign sat   = sat_reg;

    // Level of the current channel, aligned to the accumulator's binary point,
    // and the next accumulator value (truncating fixed-point multiply).
    always_comb begin
        l_cur   = l_reg[ch];
        l_thr   = {l_cur, {FRAC_W{1'b0}}};
        prod    = PROD_W'(x) * PROD_W'(TOE_V);
        x_next  = prod[PROD_W-1:FRAC_W];
        last_ch = (ch == CH_LAST);
    end

`ifdef DIFF_ORDER_CACHE_EN
    logic [CHANNELS-1:0][DATA_W-1:0] l_last;
    logic [CHANNELS-1:0]             cv;

    assign cache_hit = cv[ch] && (l_last[ch] == l_cur);

    // Cache entries are written together with the result and cleared by reset.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            l_last <= '0;
            cv     <= '0;
        end else if (en && state == S_STORE) begin
            l_last[ch] <= l_cur;
            cv[ch]     <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    // Sequencer: walks the channels, iterates the search, stores the results.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            ch      <= '0;
            l_reg   <= '0;
            x       <= '0;
            n       <= '0;
            sat_i   <= 1'b0;
            n_reg   <= '0;
            sat_reg <= '0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        l_reg <= l_mv;
                        ch    <= '0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cache_hit) begin
                        // Unchanged level: keep the stored result and move on.
                        if (last_ch) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            ch    <= ch + 1'b1;
                            state <= S_LOAD;
                        end
                    end else begin
                        x     <= BG_V;
                        n     <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (l_cur == '0) begin
                        // A zero level can never be reached; report the cap.
                        n     <= N_MAX_V;
                        sat_i <= 1'b1;
                        state <= S_STORE;
                    end else if (x <= l_thr) begin
                        sat_i <= 1'b0;
                        state <= S_STORE;
                    end else if (n == N_MAX_V) begin
                        sat_i <= 1'b1;
                        state <= S_STORE;
                    end else begin
                        x <= x_next;
                        n <= n + 1'b1;
                    end
                end
                S_STORE: begin
                    n_reg[ch]   <= n;
                    sat_reg[ch] <= sat_i;
                    if (last_ch) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/diff_order_calc_mc.md
Name: diff_order_calc_mc

Overview:
- Multi-channel, fully integer successor to the single-channel FP-IP difference-order calculator.
- Each channel computes N = smallest n ≥ 0 such that BG·TOEⁿ ≤ L, where L is the channel's measured level in mV. This is the same result as ceil((ln L − ln BG)/ln TOE), but it uses an iterative fixed-point multiply instead of log/FP cores.
- Sits between the ADC level registers and the HPS-visible order registers. Channels are processed sequentially under a start/done handshake.

Parameters:
- CHANNELS, 4, number of independent level inputs.
- DATA_W, 12, width of each mV input.
- FRAC_W, 16, fractional bits of the internal accumulator (unsigned Q(DATA_W).(FRAC_W)).
- N_W, 16, width of each result.
- N_MAX, 40, iteration cap; must be < 2^N_W.
- BG_Q, 63163597, background level 963.8 mV in Q(DATA_W).(FRAC_W).
- TOE_Q, 30782, per-order ratio 0.4697 in Q0.(FRAC_W); must be < 2^FRAC_W.

Ports:
- clk_50  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request a computation; sampled only in IDLE with en=1.
- l_mv  in  CHANNELS*DATA_W  packed levels; channel c at [c*DATA_W +: DATA_W].
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  single-cycle pulse when all channels have been stored.
- n_out  out  CHANNELS*N_W  packed results; channel c at [c*N_W +: N_W].
- sat  out  CHANNELS  per-channel flag: result was capped at N_MAX.

Behaviour:
- Reset (rst_n=0 at a clock edge, when en is 1 or 0): FSM to IDLE; busy, done, n_out, sat, and the channel index go to 0. Reset mid-computation aborts the run with no done pulse.
- FSM states: IDLE, LOAD, ITER, STORE, DONE.
- IDLE: on start=1, latch all l_mv into l_reg, set ch=0, go to LOAD. start is ignored in every other state.
- LOAD: x ← BG_Q, n ← 0, go to ITER.
- ITER, evaluated in priority order:
  - If l_reg[ch]==0: n ← N_MAX, sat_i ← 1, go to STORE.
  - Else if x ≤ {l_reg[ch], FRAC_W'b0}: sat_i ← 0, go to STORE.
  - Else if n==N_MAX: sat_i ← 1, go to STORE.
  - Else: x ← (x·TOE_Q) >> FRAC_W (truncating; product width DATA_W+2·FRAC_W), n ← n+1, stay in ITER.
- STORE: n_out[ch] ← n, sat[ch] ← sat_i. If ch==CHANNELS-1 go to DONE; else ch ← ch+1 and go to LOAD.
- DONE: done=1 for exactly this cycle, go to IDLE.
- Latency:
  - Channel with result n (not zero-input): n+3 cycles.
  - Zero-input channel: 3 cycles.
  - Total run: Σ per-channel cycles + 1, measured from the cycle after start is accepted to done inclusive.
- Outputs are registered. n_out[c] and sat[c] change only in STORE for channel c and otherwise hold. Results from a prior run remain visible during a new run until overwritten.
- en=0 in any state freezes the FSM; done is held at its current value.

Optional Feature:
- Macro: DIFF_ORDER_CACHE_EN.
- Defined:
  - Per-channel cache: last level l_last[c] and a valid bit cv[c], cleared by reset.
  - In LOAD, if cv[ch]=1 and l_reg[ch]==l_last[ch], skip ITER/STORE. n_out/sat are retained; advance ch or go to DONE directly. The channel costs 1 cycle.
  - Otherwise compute normally; STORE also writes l_last[ch] and sets cv[ch].
- Undefined: no cache storage; every channel is always recomputed.

Test Plan:
- Defaults, l_mv={1000,500,150,0}, start → n_out={0,1,3,40}, sat={0,0,0,1}, done 17 cycles after start is accepted (3+4+6+3+1), busy high throughout.
- Defaults, all channels 963 → all n_out=1 (963 < 963.8), sat=0. Then all channels 964 → all n_out=0.
- N_MAX=2, channel 0 = 150 → n_out[0]=2, sat[0]=1. Channel 1 = 500 → n_out[1]=1, sat[1]=0.
- Pulse start again while busy → ignored: exactly one done pulse, results unchanged. Hold en=0 for 5 cycles mid-ITER → done delayed by exactly 5 cycles, results identical.
- Assert rst_n=0 during ITER of channel 2 → next cycle busy=0, n_out=0, sat=0, no done pulse. A subsequent start completes normally.
- DIFF_ORDER_CACHE_EN: run {1000,500,150,0} twice → second run done 5 cycles after accept (4×1+1), identical results. Change channel 2 only to 500 → channels 0, 1 and 3 take 1 cycle each, channel 2 takes 4 cycles, n_out[2]=1.
